// File: rtl/atb_protocol_monitor.sv
// Passive ATB monitor: checks data/flush handshake rules, flags violations as
// pulses and sticky bits, captures the first failure and counts accepted traffic.
module atb_protocol_monitor #(
  parameter int DATA_WIDTH    = 32,
  parameter int BYTES_W       = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH/8) : 1,
  parameter int CNT_WIDTH     = 16,
  parameter int FLUSH_TIMEOUT = 256
) (
  input  logic                  atclk,
  input  logic                  atresetn,
  input  logic                  atclken,
  input  logic [DATA_WIDTH-1:0] atdata,
  input  logic [BYTES_W-1:0]    atbytes,
  input  logic [6:0]            atid,
  input  logic                  atvalid,
  input  logic                  atready,
  input  logic                  afvalid,
  input  logic                  afready,
  input  logic                  clr,
  output logic [6:0]            err_pulse,
  output logic [6:0]            err_sticky,
  output logic                  first_err_valid,
  output logic [2:0]            first_err_id,
  output logic                  flush_active,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [CNT_WIDTH-1:0]  byte_count
);

  localparam int NCHK   = 7;
  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_WAIT  = 2'd1,
    F_STUCK = 2'd2
  } flush_state_e;

  flush_state_e          flush_state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_inc;
  logic                  stalled_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BYTES_W-1:0]    bytes_q;
  logic [6:0]            id_q;
  logic                  af_pend_q;

  logic                  beat;
  logic                  id_reserved;
  logic                  bytes_bad;
  logic                  timeout_hit;
  logic [NCHK-1:0]       errs;
  logic [2:0]            first_idx;
  logic [CNT_WIDTH-1:0]  xfer_base;
  logic [CNT_WIDTH-1:0]  byte_base;
  logic [CNT_WIDTH-1:0]  xfer_next;
  logic [CNT_WIDTH-1:0]  byte_next;
  logic [CNT_WIDTH:0]    byte_sum;

  assign beat        = atvalid && atready;
  // Reserved IDs: 0x00 and the whole 0x70..0x7F block except 0x7D.
  assign id_reserved = (atid == 7'h00) || ((atid >= 7'h70) && (atid != 7'h7D));
  assign wait_inc    = wait_cnt + WAIT_W'(1);
  assign timeout_hit = (flush_state == F_WAIT) && afvalid && !afready &&
                       (wait_inc == WAIT_W'(FLUSH_TIMEOUT));

  generate
    if (DATA_WIDTH == 8) begin : g_bytes_w8
      assign bytes_bad = 1'b0;
    end else begin : g_bytes_wide
      assign bytes_bad = atvalid && (32'(atbytes) > 32'(DATA_WIDTH/8 - 1));
    end
  endgenerate

  always_comb begin
    errs      = '0;
    errs[0]   = beat && id_reserved;
    errs[1]   = bytes_bad;
    errs[2]   = stalled_q && !atvalid;
    errs[3]   = stalled_q && atvalid &&
                ((atdata != data_q) || (atbytes != bytes_q) || (atid != id_q));
    errs[4]   = af_pend_q && !afvalid;
    errs[5]   = afready && !afvalid;
    errs[6]   = timeout_hit;
    first_idx = '0;
    for (int i = NCHK-1; i >= 0; i--) begin
      if (errs[i]) first_idx = 3'(i);
    end
  end

  // Clear is folded in before the current beat so a same-cycle beat survives it.
  assign xfer_base = clr ? '0 : xfer_count;
  assign byte_base = clr ? '0 : byte_count;
  assign xfer_next = (&xfer_base) ? xfer_base : xfer_base + CNT_WIDTH'(1);
  assign byte_sum  = {1'b0, byte_base} + (CNT_WIDTH+1)'(atbytes) + (CNT_WIDTH+1)'(1);
  assign byte_next = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];

  assign flush_active = (flush_state != F_IDLE);

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      flush_state <= F_IDLE;
      wait_cnt    <= '0;
    end else if (atclken) begin
      case (flush_state)
        F_IDLE: begin
          if (afvalid && !afready) begin
            flush_state <= F_WAIT;
            wait_cnt    <= WAIT_W'(1);
          end
        end
        F_WAIT: begin
          if (afready || !afvalid) begin
            flush_state <= F_IDLE;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_inc;
            if (timeout_hit) flush_state <= F_STUCK;
          end
        end
        F_STUCK: begin
          if (afready || !afvalid) begin
            flush_state <= F_IDLE;
            wait_cnt    <= '0;
          end
        end
        default: begin
          flush_state <= F_IDLE;
          wait_cnt    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      err_pulse       <= '0;
      err_sticky      <= '0;
      first_err_valid <= 1'b0;
      first_err_id    <= '0;
      xfer_count      <= '0;
      byte_count      <= '0;
      stalled_q       <= 1'b0;
      data_q          <= '0;
      bytes_q         <= '0;
      id_q            <= '0;
      af_pend_q       <= 1'b0;
    end else begin
      err_pulse <= '0;
      if (atclken) begin
        err_pulse  <= errs;
        err_sticky <= (clr ? '0 : err_sticky) | errs;
        if ((clr || !first_err_valid) && (|errs)) begin
          first_err_valid <= 1'b1;
          first_err_id    <= first_idx;
        end else if (clr) begin
          first_err_valid <= 1'b0;
          first_err_id    <= '0;
        end
        if (beat) begin
          xfer_count <= xfer_next;
          byte_count <= byte_next;
        end else if (clr) begin
          xfer_count <= '0;
          byte_count <= '0;
        end
        stalled_q <= atvalid && !atready;
        data_q    <= atdata;
        bytes_q   <= atbytes;
        id_q      <= atid;
        af_pend_q <= afvalid && !afready;
      end
    end
  end

endmodule

// File: tb/tb_atb_protocol_monitor.sv
// Bench for atb_protocol_monitor: directed scenarios plus randomized traffic,
// all compared against a rule-level model of the ATB checks kept here.
module tb_atb_protocol_monitor;

  localparam int DW   = 32;
  localparam int BW   = 3;
  localparam int CW   = 16;
  localparam int FT   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          atclk;
  logic          atresetn;
  logic          atclken;
  logic [DW-1:0] atdata;
  logic [BW-1:0] atbytes;
  logic [6:0]    atid;
  logic          atvalid, atready, afvalid, afready, clr;
  logic [6:0]    err_pulse, err_sticky;
  logic          first_err_valid;
  logic [2:0]    first_err_id;
  logic          flush_active;
  logic [CW-1:0] xfer_count, byte_count;

  int checks   = 0;
  int failures = 0;

  // Model state: previous sampled handshake and how long the flush has waited.
  logic          m_stalled;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_bytes;
  logic [6:0]    m_id;
  logic          m_af_pend;
  int            m_wait;
  logic [6:0]    exp_pulse, exp_sticky;
  logic          exp_fev;
  logic [2:0]    exp_fid;
  logic          exp_active;
  int            exp_xfer, exp_bytes;
  logic [6:0]    exp_q[$];

  atb_protocol_monitor #(
    .DATA_WIDTH(DW), .BYTES_W(BW), .CNT_WIDTH(CW), .FLUSH_TIMEOUT(FT)
  ) dut (
    .atclk(atclk), .atresetn(atresetn), .atclken(atclken),
    .atdata(atdata), .atbytes(atbytes), .atid(atid),
    .atvalid(atvalid), .atready(atready), .afvalid(afvalid), .afready(afready),
    .clr(clr), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .first_err_valid(first_err_valid), .first_err_id(first_err_id),
    .flush_active(flush_active), .xfer_count(xfer_count), .byte_count(byte_count)
  );

  initial begin
    atclk = 1'b0;
    forever #5 atclk = ~atclk;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  function automatic logic is_reserved(input logic [6:0] id);
    return (id == 7'h00) || (id >= 7'h70 && id <= 7'h7C) || (id == 7'h7E) || (id == 7'h7F);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_stalled = 0; m_data = '0; m_bytes = '0; m_id = '0; m_af_pend = 0; m_wait = 0;
    exp_pulse = '0; exp_sticky = '0; exp_fev = 0; exp_fid = '0; exp_active = 0;
    exp_xfer = 0; exp_bytes = 0;
  endtask

  task automatic model_step();
    logic [6:0] e;
    logic       acc;
    e = '0;
    if (!atclken) begin
      exp_pulse = '0;
      return;
    end
    acc  = atvalid && atready;
    e[0] = acc && is_reserved(atid);
    e[1] = atvalid && (int'(atbytes) > DW/8 - 1);
    e[2] = m_stalled && !atvalid;
    e[3] = m_stalled && atvalid && (atdata !== m_data || atbytes !== m_bytes || atid !== m_id);
    e[4] = m_af_pend && !afvalid;
    e[5] = afready && !afvalid;
    if (afvalid && !afready) m_wait++;
    else m_wait = 0;
    e[6] = (m_wait == FT);
    if (clr) begin
      exp_sticky = '0; exp_fev = 0; exp_fid = '0; exp_xfer = 0; exp_bytes = 0;
    end
    exp_sticky = exp_sticky | e;
    if (!exp_fev && e != 0) begin
      exp_fev = 1;
      for (int i = 6; i >= 0; i--) if (e[i]) exp_fid = 3'(i);
    end
    if (acc) begin
      exp_xfer  = sat(exp_xfer + 1);
      exp_bytes = sat(exp_bytes + int'(atbytes) + 1);
    end
    exp_pulse  = e;
    exp_active = (m_wait > 0);
    m_stalled  = atvalid && !atready;
    m_data     = atdata; m_bytes = atbytes; m_id = atid;
    m_af_pend  = afvalid && !afready;
  endtask

  task automatic idle_inputs();
    atclken = 1; atdata = '0; atbytes = '0; atid = 7'h10;
    atvalid = 0; atready = 0; afvalid = 0; afready = 0; clr = 0;
  endtask

  // One sampled edge: DUT and model see the same inputs; outputs read 1 after.
  task automatic tick();
    @(posedge atclk);
    if (atresetn) model_step();
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (err_pulse !== 7'd0) begin failures++; $display("FAIL reset_pulse: got %b want 0", err_pulse); end
    checks++; if (err_sticky !== 7'd0) begin failures++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
    checks++; if (first_err_valid !== 1'b0 || first_err_id !== 3'd0) begin failures++; $display("FAIL reset_first: got %b/%0d want 0/0", first_err_valid, first_err_id); end
    checks++; if (flush_active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b want 0", flush_active); end
    checks++; if (xfer_count !== '0 || byte_count !== '0) begin failures++; $display("FAIL reset_counts: got %0d/%0d want 0/0", xfer_count, byte_count); end
    #9;
    atresetn = 1;
    tick();
    tick();
    checks++; if (err_pulse !== 7'd0 || xfer_count !== '0) begin failures++; $display("FAIL reset_idle: got %b/%0d want 0/0", err_pulse, xfer_count); end
  endtask

  task automatic test_basic_counts();
    idle_inputs();
    atvalid = 1; atready = 1; atid = 7'h10; atbytes = 3;
    for (int i = 0; i < 5; i++) begin
      atdata = DW'($urandom);
      tick();
    end
    atid = 7'h7D; atbytes = 1;
    tick();
    idle_inputs();
    checks++; if (xfer_count !== 16'd6) begin failures++; $display("FAIL basic_xfer: got %0d want 6", xfer_count); end
    checks++; if (byte_count !== 16'd22) begin failures++; $display("FAIL basic_bytes: got %0d want 22", byte_count); end
    checks++; if (err_sticky !== 7'd0) begin failures++; $display("FAIL basic_sticky: got %b want 0", err_sticky); end
    checks++; if (xfer_count !== CW'(exp_xfer) || byte_count !== CW'(exp_bytes)) begin failures++; $display("FAIL basic_model: got %0d/%0d want %0d/%0d", xfer_count, byte_count, exp_xfer, exp_bytes); end
  endtask

  task automatic test_reserved_id();
    idle_inputs();
    atvalid = 1; atready = 1; atid = 7'h7E; atbytes = 0;
    tick();
    idle_inputs();
    checks++; if (err_pulse !== 7'b0000001) begin failures++; $display("FAIL rsv_pulse: got %b want 0000001", err_pulse); end
    checks++; if (err_sticky !== 7'b0000001) begin failures++; $display("FAIL rsv_sticky: got %b want 0000001", err_sticky); end
    checks++; if (first_err_valid !== 1'b1 || first_err_id !== 3'd0) begin failures++; $display("FAIL rsv_first: got %b/%0d want 1/0", first_err_valid, first_err_id); end
    tick();
    checks++; if (err_pulse !== 7'd0) begin failures++; $display("FAIL rsv_pulse_end: got %b want 0", err_pulse); end
  endtask

  task automatic test_stall_payload();
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    atvalid = 1; atready = 0; atbytes = 3; atdata = 32'hA5A5A5A5;
    tick();
    checks++; if (err_pulse !== 7'd0 || err_sticky !== 7'd0) begin failures++; $display("FAIL stall_first: got %b/%b want 0/0", err_pulse, err_sticky); end
    atdata = 32'h5A5A5A5A;
    tick();
    checks++; if (err_pulse !== 7'b0001000) begin failures++; $display("FAIL stall_change_pulse: got %b want 0001000", err_pulse); end
    checks++; if (err_sticky !== 7'b0001000 || first_err_id !== 3'd3) begin failures++; $display("FAIL stall_change_capture: got %b/%0d want 0001000/3", err_sticky, first_err_id); end
    atvalid = 0;
    tick();
    checks++; if (err_pulse !== 7'b0000100) begin failures++; $display("FAIL stall_drop_pulse: got %b want 0000100", err_pulse); end
    checks++; if (err_sticky !== 7'b0001100 || first_err_id !== 3'd3) begin failures++; $display("FAIL stall_drop_capture: got %b/%0d want 0001100/3", err_sticky, first_err_id); end
  endtask

  task automatic test_multi_error();
    idle_inputs();
    clr = 1; atvalid = 1; atready = 1; atid = 7'h00; atbytes = 5; afready = 1;
    tick();
    idle_inputs();
    checks++; if (err_pulse !== 7'b0100011) begin failures++; $display("FAIL multi_pulse: got %b want 0100011", err_pulse); end
    checks++; if (err_sticky !== 7'b0100011) begin failures++; $display("FAIL multi_sticky: got %b want 0100011", err_sticky); end
    checks++; if (first_err_valid !== 1'b1 || first_err_id !== 3'd0) begin failures++; $display("FAIL multi_first: got %b/%0d want 1/0", first_err_valid, first_err_id); end
    checks++; if (xfer_count !== 16'd1 || byte_count !== 16'd6) begin failures++; $display("FAIL multi_counts: got %0d/%0d want 1/6", xfer_count, byte_count); end
  endtask

  task automatic test_afvalid_drop();
    idle_inputs();
    clr = 1; afvalid = 1;
    tick();
    clr = 0;
    checks++; if (flush_active !== 1'b1 || err_sticky !== 7'd0) begin failures++; $display("FAIL afdrop_wait: got %b/%b want 1/0", flush_active, err_sticky); end
    afvalid = 0;
    tick();
    checks++; if (err_pulse !== 7'b0010000 || flush_active !== 1'b0) begin failures++; $display("FAIL afdrop_pulse: got %b/%b want 0010000/0", err_pulse, flush_active); end
    checks++; if (first_err_id !== 3'd4 || err_sticky !== exp_sticky) begin failures++; $display("FAIL afdrop_capture: got %0d/%b want 4/%b", first_err_id, err_sticky, exp_sticky); end
  endtask

  task automatic test_flush_timeout();
    idle_inputs();
    clr = 1;
    tick();
    clr = 0; afvalid = 1;
    for (int i = 1; i <= FT + 3; i++) begin
      tick();
      checks++; if (flush_active !== 1'b1) begin failures++; $display("FAIL flush_active_%0d: got %b want 1", i, flush_active); end
      checks++; if (err_pulse !== ((i == FT) ? 7'b1000000 : 7'd0)) begin failures++; $display("FAIL flush_pulse_%0d: got %b want %b", i, err_pulse, (i == FT) ? 7'b1000000 : 7'd0); end
    end
    afready = 1;
    tick();
    checks++; if (flush_active !== 1'b0 || err_pulse !== 7'd0) begin failures++; $display("FAIL flush_release: got %b/%b want 0/0", flush_active, err_pulse); end
    idle_inputs();
    tick();
    checks++; if (err_sticky !== 7'b1000000) begin failures++; $display("FAIL flush_sticky: got %b want 1000000", err_sticky); end
  endtask

  task automatic test_clken_stall();
    logic en_seq[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic rdy_seq[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] d;
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    d = DW'($urandom);
    for (int i = 0; i < 6; i++) begin
      atclken = en_seq[i]; atready = rdy_seq[i];
      atvalid = 1; afvalid = 1; atbytes = 2;
      atdata  = en_seq[i] ? d : ~d;
      tick();
      checks++; if (err_pulse !== exp_pulse || flush_active !== exp_active) begin failures++; $display("FAIL clken_step_%0d: got %b/%b want %b/%b", i, err_pulse, flush_active, exp_pulse, exp_active); end
    end
    checks++; if (err_pulse !== 7'b1000000 || err_sticky !== 7'b1000000) begin failures++; $display("FAIL clken_timeout: got %b/%b want 1000000/1000000", err_pulse, err_sticky); end
    idle_inputs();
    afvalid = 1; afready = 1;
    tick();
    checks++; if (err_pulse !== 7'd0 || flush_active !== 1'b0) begin failures++; $display("FAIL clken_release: got %b/%b want 0/0", err_pulse, flush_active); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    atvalid = 1; atready = 0; afvalid = 1; atbytes = 1;
    tick();
    tick();
    #2;
    atresetn = 0;
    #1;
    model_reset();
    checks++; if (flush_active !== 1'b0 || err_sticky !== 7'd0 || xfer_count !== '0) begin failures++; $display("FAIL midreset_outputs: got %b/%b/%0d want 0/0/0", flush_active, err_sticky, xfer_count); end
    #3;
    atresetn = 1;
    idle_inputs();
    tick();
    checks++; if (err_pulse !== 7'd0 || err_sticky !== 7'd0) begin failures++; $display("FAIL midreset_first: got %b/%b want 0/0", err_pulse, err_sticky); end
  endtask

  task automatic test_random();
    logic [6:0] want;
    exp_q.delete();
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      atclken = ($urandom_range(0, 9) != 0);
      clr     = ($urandom_range(0, 31) == 0);
      atvalid = ($urandom_range(0, 9) < 7);
      atready = $urandom_range(0, 1) == 1;
      if (m_stalled && $urandom_range(0, 9) < 8) begin
        atdata = m_data; atbytes = m_bytes; atid = m_id;
      end else begin
        atdata  = DW'($urandom);
        atbytes = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(4, 7)) : BW'($urandom_range(0, 3));
        atid    = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'($urandom_range(1, 16'h6F));
      end
      afvalid = ($urandom_range(0, 2) == 0) ? ~afvalid : afvalid;
      afready = ($urandom_range(0, 4) == 0);
      tick();
      exp_q.push_back(exp_pulse);
      want = exp_q.pop_front();
      checks++; if (err_pulse !== want) begin failures++; $display("FAIL rnd_pulse_%0d: got %b want %b", n, err_pulse, want); end
      checks++; if (err_sticky !== exp_sticky) begin failures++; $display("FAIL rnd_sticky_%0d: got %b want %b", n, err_sticky, exp_sticky); end
      checks++; if (first_err_valid !== exp_fev || (exp_fev && first_err_id !== exp_fid)) begin failures++; $display("FAIL rnd_first_%0d: got %b/%0d want %b/%0d", n, first_err_valid, first_err_id, exp_fev, exp_fid); end
      checks++; if (flush_active !== exp_active) begin failures++; $display("FAIL rnd_active_%0d: got %b want %b", n, flush_active, exp_active); end
      checks++; if (xfer_count !== CW'(exp_xfer) || byte_count !== CW'(exp_bytes)) begin failures++; $display("FAIL rnd_counts_%0d: got %0d/%0d want %0d/%0d", n, xfer_count, byte_count, exp_xfer, exp_bytes); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    clr = 1; atvalid = 1; atready = 1; atbytes = 7;
    tick();
    clr = 0;
    for (int i = 0; i < 8190; i++) tick();
    checks++; if (byte_count !== 16'hFFF8 || xfer_count !== 16'd8191) begin failures++; $display("FAIL sat_pre: got %0h/%0d want fff8/8191", byte_count, xfer_count); end
    tick();
    checks++; if (byte_count !== 16'hFFFF) begin failures++; $display("FAIL sat_byte_overflow: got %0h want ffff", byte_count); end
    for (int i = 0; i < 65534 - 8192; i++) tick();
    checks++; if (xfer_count !== 16'hFFFE || xfer_count !== CW'(exp_xfer)) begin failures++; $display("FAIL sat_xfer_fffe: got %0h want fffe", xfer_count); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (xfer_count !== 16'hFFFF || byte_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %0h/%0h want ffff/ffff", xfer_count, byte_count); end
    clr = 1; atbytes = 0;
    tick();
    idle_inputs();
    checks++; if (xfer_count !== 16'd1 || byte_count !== 16'd1) begin failures++; $display("FAIL sat_clr_beat: got %0d/%0d want 1/1", xfer_count, byte_count); end
  endtask

  initial begin
    idle_inputs();
    atresetn = 0;
    model_reset();
    test_reset();
    test_basic_counts();
    test_reserved_id();
    test_stall_payload();
    test_multi_error();
    test_afvalid_drop();
    test_flush_timeout();
    test_clken_stall();
    test_reset_midflight();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atb_protocol_monitor.md
# atb_protocol_monitor

Passive, parametrised ATB protocol monitor bound alongside the ATB interface in the test top. It samples the trace data channel and the flush handshake, and checks the payload handshake, payload stability, reserved trace IDs, atbytes range and flush-handshake rules. It reports each violation as a one-cycle pulse and a sticky flag, captures the first failure, and keeps saturating transfer and byte counters for scoreboard cross-checks. It drives no ATB signal.

## Interface
- DATA_WIDTH, 32: atdata width; one of 8, 16, 32, 64, 128.
- BYTES_W, $clog2(DATA_WIDTH/8) (minimum 1): atbytes width.
- CNT_WIDTH, 16: width of the transfer and byte counters.
- FLUSH_TIMEOUT, 256: sampled cycles afvalid may stay high without afready; range 2..65535.
- atclk  in  1  trace clock.
- atresetn  in  1  asynchronous, active-low reset.
- atclken  in  1  clock enable; inputs are sampled only when high.
- atdata  in  DATA_WIDTH  trace payload.
- atbytes  in  BYTES_W  valid bytes minus 1.
- atid  in  7  trace source ID.
- atvalid, atready  in  1  data handshake.
- afvalid, afready  in  1  flush handshake.
- clr  in  1  synchronous clear of sticky flags, first-error capture and counters.
- err_pulse  out  7  per-check pulse, one cycle.
- err_sticky  out  7  per-check sticky flag.
- first_err_valid  out  1  first-error capture is valid.
- first_err_id  out  3  index of the first failing check.
- flush_active  out  1  flush FSM is not IDLE.
- xfer_count  out  CNT_WIDTH  accepted beats.
- byte_count  out  CNT_WIDTH  accepted bytes.

## Operation
- A sampled cycle is a posedge atclk with atclken=1. A beat is accepted on a sampled cycle with atvalid&&atready. "Stalled" means the previous sampled cycle had atvalid=1 and atready=0.
- Check 0, RESERVED_ID: accepted beat with atid equal to 7'h00, 7'h70..7'h7C, 7'h7E or 7'h7F.
- Check 1, BYTES_RANGE: atvalid=1 and atbytes > DATA_WIDTH/8-1. This check can never fire when DATA_WIDTH=8.
- Check 2, VALID_DROP: stalled and atvalid=0.
- Check 3, PAYLOAD_CHANGE: stalled, atvalid=1, and atdata, atbytes or atid differs from the previous sampled value.
- Check 4, AFVALID_DROP: the previous sampled cycle had afvalid=1 and afready=0, and afvalid is now 0.
- Check 5, AFREADY_UNSOLICITED: afready=1 while afvalid=0.
- Check 6, FLUSH_TIMEOUT: reported once per flush, when the wait counter reaches FLUSH_TIMEOUT.
- Flush FSM states:
  - IDLE: afvalid=1 and afready=1 completes the flush in the same sampled cycle and the FSM stays IDLE. Otherwise afvalid=1 moves to WAIT with the wait counter set to 1.
  - WAIT: afready=1 returns to IDLE. afvalid=0 returns to IDLE and check 4 fires. Otherwise the counter increments; when it reaches FLUSH_TIMEOUT, check 6 fires and the FSM moves to STUCK.
  - STUCK: afready=1 or afvalid=0 returns to IDLE. Check 4 still applies on an early drop.
- Counters, on each accepted beat:
  - xfer_count += 1.
  - byte_count += atbytes+1.
  - Both saturate at all-ones and never wrap. byte_count saturates, rather than truncating, when the addition overflows.
- Multiple checks failing on the same sampled cycle set all of the corresponding pulse and sticky bits. first_err_id captures the lowest index, and only if first_err_valid was 0.
- clr:
  - Clears err_sticky, first_err_valid, first_err_id and both counters.
  - Events on the same sampled cycle are applied after the clear: sticky bits and capture reflect that cycle's errors, and the counters hold that beat's contribution.
  - clr does not reset the flush FSM or the stall tracking.

## Timing
- All outputs are registered and update one atclk edge after the sampled cycle that caused them.
- err_pulse is high for exactly one atclk cycle. It is 0 on any edge where atclken=0.
- When atclken=0: state, counters and sticky flags hold; the FSM and the flush wait counter do not advance.
- Asserting atresetn low takes effect immediately, including mid-flush or mid-stall:
  - every output goes to 0, the FSM goes to IDLE, and the stall history is cleared;
  - the first sampled cycle after reset cannot trigger checks 2, 3 or 4.
- flush_active is 1 exactly in the cycles after the FSM has entered WAIT or STUCK.

## Test plan
- Accepted beats with atid=7'h10, atbytes=3 (×5), then atid=7'h7D, atbytes=1 (×1) -> xfer_count=6, byte_count=22, err_sticky=0.
- Accepted beat with atid=7'h7E -> err_pulse[0] high for one cycle, err_sticky=7'b0000001, first_err_id=0.
- Stall with atdata=32'hA5A5A5A5, then atdata=32'h5A5A5A5A while still stalled, then atvalid=0 while still stalled:
  - err_sticky[3] set, then err_sticky[2] set;
  - first_err_id stays 3.
- FLUSH_TIMEOUT=4; afvalid held high with afready=0:
  - flush_active=1 and err_pulse[6] fires once, on the 4th sampled cycle;
  - afready=1 then returns the FSM to IDLE with no further errors.
- atclken toggled 1,0,1,0 during a stalled beat: wait and stall tracking advance only on enabled edges and no false check 3 fires.
- With xfer_count=16'hFFFE: 3 accepted beats -> xfer_count=16'hFFFF. Then clr on the same cycle as an accepted beat with atbytes=0 -> xfer_count=1, byte_count=1.
